// File: rtl/instr_encoder.sv
// RV32I field-bundle to instruction-word encoder that streams legal words into IMEM
// at an auto-incrementing word address, flagging illegal bundles instead of writing them.
module instr_encoder #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cls,
    input  logic [3:0]        alu_op,
    input  logic [2:0]        br_op,
    input  logic [3:0]        ld_op,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    input  logic [4:0]        rd_addr,
    input  logic [31:0]       imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err,
    output logic              err_sticky,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic [3:0] {
        CLS_OP, CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
    } cls_e;

    logic [ADDR_W:0] ptr;
    logic [31:0]     word;
    logic            legal;
    logic [2:0]      f3_alu, f3_ld, f3_br;
    logic [6:0]      funct7;
    logic            alu_ok, is_shift, ld_ok, st_ok, br_ok;
    logic            i_ok, b_ok, j_ok, u_ok, shamt_ok;
    logic            accept;

    // Immediate range checks: the value must be exactly what the decoder would sign-extend.
    assign i_ok     = (imm == {{20{imm[11]}}, imm[11:0]});
    assign b_ok     = ~imm[0] & (imm == {{19{imm[12]}}, imm[12:0]});
    assign j_ok     = ~imm[0] & (imm == {{11{imm[20]}}, imm[20:0]});
    assign u_ok     = (imm[11:0] == 12'd0);
    assign shamt_ok = (imm[31:5] == 27'd0);
    assign alu_ok   = (alu_op <= 4'd9);
    assign is_shift = (alu_op >= 4'd7) && (alu_op <= 4'd9);
    assign funct7   = {1'b0, (alu_op == 4'd1) || (alu_op == 4'd9), 5'b0};
    assign st_ok    = (ld_op == 4'b1001) || (ld_op == 4'b1011) || (ld_op == 4'b1111);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        f3_alu = 3'b000;
        unique case (alu_op)
            4'd2:    f3_alu = 3'b010;
            4'd3:    f3_alu = 3'b011;
            4'd4:    f3_alu = 3'b100;
            4'd5:    f3_alu = 3'b110;
            4'd6:    f3_alu = 3'b111;
            4'd7:    f3_alu = 3'b001;
            4'd8,
            4'd9:    f3_alu = 3'b101;
            default: f3_alu = 3'b000;
        endcase

        f3_ld = 3'b000;
        ld_ok = 1'b1;
        case (ld_op)
            4'b1001: f3_ld = 3'b000;
            4'b1011: f3_ld = 3'b001;
            4'b1111: f3_ld = 3'b010;
            4'b0001: f3_ld = 3'b100;
            4'b0011: f3_ld = 3'b101;
            default: ld_ok = 1'b0;
        endcase

        f3_br = 3'b000;
        br_ok = 1'b1;
        case (br_op)
            3'd0:    f3_br = 3'b000;
            3'd1:    f3_br = 3'b001;
            3'd2:    f3_br = 3'b100;
            3'd3:    f3_br = 3'b101;
            3'd4:    f3_br = 3'b110;
            3'd5:    f3_br = 3'b111;
            default: br_ok = 1'b0;
        endcase
    end

    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        case (cls)
            CLS_OP: begin
                word  = {funct7, rs2_addr, rs1_addr, f3_alu, rd_addr, 7'b0110011};
                legal = alu_ok;
            end
            CLS_OPIMM: begin
                if (is_shift) begin
                    word  = {funct7, imm[4:0], rs1_addr, f3_alu, rd_addr, 7'b0010011};
                    legal = shamt_ok;
                end else begin
                    word  = {imm[11:0], rs1_addr, f3_alu, rd_addr, 7'b0010011};
                    legal = alu_ok && (alu_op != 4'd1) && i_ok;
                end
            end
            CLS_LOAD: begin
                word  = {imm[11:0], rs1_addr, f3_ld, rd_addr, 7'b0000011};
                legal = ld_ok && i_ok;
            end
            CLS_STORE: begin
                word  = {imm[11:5], rs2_addr, rs1_addr, f3_ld, imm[4:0], 7'b0100011};
                legal = st_ok && i_ok;
            end
            CLS_BRANCH: begin
                word  = {imm[12], imm[10:5], rs2_addr, rs1_addr, f3_br, imm[4:1], imm[11], 7'b1100011};
                legal = br_ok && b_ok;
            end
            CLS_JAL: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd_addr, 7'b1101111};
                legal = j_ok;
            end
            CLS_JALR: begin
                word  = {imm[11:0], rs1_addr, 3'b000, rd_addr, 7'b1100111};
                legal = i_ok;
            end
            CLS_LUI: begin
                word  = {imm[31:12], rd_addr, 7'b0110111};
                legal = u_ok;
            end
            CLS_AUIPC: begin
                word  = {imm[31:12], rd_addr, 7'b0010111};
                legal = u_ok;
            end
            default: legal = 1'b0;
        endcase
    end

    assign full     = (ptr == DEPTH);
    assign in_ready = ~full & (~imem_we | imem_ready);
    assign accept   = in_valid & in_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr        <= '0;
            count      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err <= 1'b0;
            if (imem_we && imem_ready) begin
                count   <= count + (ADDR_W+1)'(1);
                imem_we <= 1'b0;
            end
            // A new acceptance may overlap the retiring write, giving one word per cycle.
            if (accept) begin
                if (legal) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr[ADDR_W-1:0];
                    imem_wdata <= word;
                    ptr        <= ptr + (ADDR_W+1)'(1);
                end else begin
                    err        <= 1'b1;
                    err_sticky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder and program loader: the inverse of the core's instruction decoder. Accepts one decoded-field bundle per handshake (instruction class, alu_op/br_op/ld_op codes, register addresses, 32-bit immediate) and packs it into a 32-bit instruction word. Each legal word is written to instruction memory at an auto-incrementing word address. Sits in the test/boot infrastructure in front of the IMEM write port, so benches and the boot ROM can emit programs in decoder-field form.

## Interface
- ADDR_W, 11: IMEM word-address width. DEPTH = 2**ADDR_W words.
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  synchronous restart: pointer, count and error state return to reset values
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept the bundle this cycle
- cls  in  4  instruction class: 0 OP, 1 OPIMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 illegal
- alu_op  in  4  0 add, 1 sub, 2 slt, 3 sltu, 4 xor, 5 or, 6 and, 7 sll, 8 srl, 9 sra
- br_op  in  3  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU
- ld_op  in  4  1001 byte, 1011 half, 1111 word, 0001 byte-unsigned, 0011 half-unsigned
- rs1_addr, rs2_addr, rd_addr  in  5 each  register fields
- imm  in  32  sign-extended immediate, in the same form the decoder produces
- imem_we  out  1  write request to IMEM
- imem_ready  in  1  IMEM accepts the write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- err  out  1  one-cycle pulse: the bundle accepted in the previous cycle was illegal
- err_sticky  out  1  set by err, cleared only by rst/clr
- full  out  1  ptr == DEPTH
- count  out  ADDR_W+1  number of words committed to IMEM (imem_we & imem_ready)

## Operation
- Encode: opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 for cls 0-8.
- funct3 from alu_op: add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111. instr[30] = 1 for sub and sra, otherwise 0. All other funct7 bits are 0.
- OPIMM shifts (7, 8, 9): instr[24:20] = imm[4:0], instr[31:25] = funct7.
- funct3 from ld_op: byte 000, half 001, word 010, byte-unsigned 100, half-unsigned 101.
- funct3 from br_op: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
- JALR funct3 is 000. Immediate bit placement follows the I/S/B/J/U formats. Unused register fields are 0.
- Illegal bundles (err=1, no IMEM write, ptr unchanged):
  - cls > 8.
  - OPIMM with alu_op 1, or alu_op > 9 in OP/OPIMM.
  - OPIMM shift with imm[31:5] != 0.
  - LOAD with an ld_op outside the 5 listed codes; STORE with ld_op other than 1001, 1011 or 1111.
  - BRANCH with br_op 6 or 7.
  - I/S immediate not equal to the sign-extension of imm[11:0].
  - B immediate with imm[0] != 0, or not the sign-extension of imm[12:0].
  - J immediate with imm[0] != 0, or not the sign-extension of imm[20:0].
  - U immediate with imm[11:0] != 0.
- ptr (ADDR_W+1 bits, internal) increments on each accepted legal bundle. It never wraps: at DEPTH, full=1 and further input is blocked.

## Timing
- Reset/clr values: imem_we 0, imem_addr 0, imem_wdata 0, err 0, err_sticky 0, full 0, count 0, ptr 0.
- Priority: rst > clr > normal operation. clr drops any pending write (imem_we=0 next cycle). rst or clr mid-stall behaves the same way.
- in_ready = ~full & (~imem_we | imem_ready). The combinational path from imem_ready to in_ready is allowed.
- Acceptance happens on a cycle with in_valid & in_ready. For a legal bundle accepted in cycle N:
  - In N+1: imem_we=1, imem_addr = ptr value before the increment, imem_wdata = encoded word.
  - Latency is 1 cycle.
- A write is held stable (addr/data/we) until imem_ready. On the cycle with imem_we & imem_ready, count increments.
- Back-to-back operation: a new acceptance in the same cycle as the write handshake gives full throughput, 1 word per cycle.
- Illegal bundle accepted in cycle N: in N+1, err=1 and err_sticky=1. imem_we is unaffected by this bundle.
- full rises in the cycle after the DEPTH-th legal acceptance. An illegal bundle never sets full.

## Test plan
- Reset, then OPIMM addi (alu_op 0, rd 1, rs1 0, imm 5) -> next cycle imem_we=1, addr 0, wdata 0x00500093. After the write handshake, count=1.
- Stream with imem_ready=1: add x3,x1,x2 -> 0x002081B3; sub -> 0x402081B3; srai x1,x1,3 -> 0x4030D093; sw x2,4(x1) -> 0x0020A223. Expect 4 consecutive cycles, addresses 0-3.
- Control flow and upper immediates: beq x1,x2,+8 -> 0x00208463; jal x1,+2048 -> 0x001000EF; lui x5,0x12345000 -> 0x123452B7.
- Backpressure: hold imem_ready=0 for 3 cycles with a pending write -> in_ready=0, addr/data stable, count unchanged. Then release -> single write, count+1.
- Illegal inputs: BRANCH with imm=3; then OPIMM with imm=2048; then cls=12 -> err pulse for each, err_sticky=1, no writes, ptr unchanged. clr -> err_sticky=0.
- Full, with ADDR_W=2: 4 legal bundles -> full=1, in_ready=0, 5th bundle stalls. clr -> full=0 and the next legal word lands at address 0.
